// File: rtl/exp_seq_ctrl.sv
// exp_seq_ctrl: sequencing controller for the multi-cycle exponent unit in EXE.
// Holds the Rn operand steady, freezes the front of the pipe while the unit
// works, latches the result and releases the pipe with a one-cycle done pulse.
// Optional feature macro: EXP_STALL_CNT_EN adds the stall_cycles counter output.
module exp_seq_ctrl #(
  parameter int unsigned LATENCY = 8,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_valid,
  input  logic        exp_en,
  input  logic        flush,
  input  logic [31:0] operand_in,
  input  logic [31:0] exp_res,
  output logic [31:0] exp_data,
  output logic [31:0] exp_result,
  output logic        freeze,
  output logic        exp_done,
  output logic        busy
`ifdef EXP_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int unsigned DATA_W = 32;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                start;

  // State, countdown, operand hold and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      result_q <= result_d;
    end
  end

  // Next-state, operand steering and result capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    result_d = result_q;
    start    = 1'b0;
    exp_data = operand_in;
    unique case (state_q)
      IDLE: begin
        start = exe_valid & exp_en & ~flush;
        if (start) begin
          hold_d  = operand_in;
          cnt_d   = CNT_LOAD;
          state_d = RUN;
        end
      end
      RUN: begin
        exp_data = hold_q;
        if (flush) begin
          // Killed instruction: drop back without touching the result
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          result_d = exp_res;
          state_d  = DONE;
        end
      end
      DONE: begin
        // Same instruction still sits in EXE; never retrigger from here
        exp_data = hold_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Freeze must fall the same cycle as a flush or an async reset
  always_comb begin
    freeze   = ~rst & (start | ((state_q == RUN) & ~flush));
    exp_done = (state_q == DONE) & ~flush;
    busy     = (state_q == RUN) | (state_q == DONE);
  end

  assign exp_result = result_q;

`ifdef EXP_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of frozen cycles
  always_comb begin
    stall_d = stall_q;
    if (freeze && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_exp_seq_ctrl.sv
// Directed bench for exp_seq_ctrl (LATENCY=8) with a result scoreboard.
module tb_exp_seq_ctrl;

  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exe_valid = 1'b0;
  logic        exp_en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] operand_in = 32'h0;
  logic [31:0] exp_res;
  logic [31:0] exp_data;
  logic [31:0] exp_result;
  logic        freeze;
  logic        exp_done;
  logic        busy;
`ifdef EXP_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] last_res = 32'h0;

  exp_seq_ctrl #(.LATENCY(LAT), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .exe_valid  (exe_valid),
    .exp_en     (exp_en),
    .flush      (flush),
    .operand_in (operand_in),
    .exp_res    (exp_res),
    .exp_data   (exp_data),
    .exp_result (exp_result),
    .freeze     (freeze),
    .exp_done   (exp_done),
    .busy       (busy)
`ifdef EXP_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] x);
    return (x * x) + 32'h0000_1234;
  endfunction

  // Exponent unit model: a pure function of the presented operand
  assign exp_res = f(exp_data);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && exp_done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected_done observed result %h expected no pulse", exp_result);
      end else begin
        chk("sb_result", exp_result, sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    step();
    exe_valid = 1'b0;
    exp_en    = 1'b0;
    flush     = 1'b0;
    #1;
  endtask

  // One exponent op starting next cycle; flush_cyc<0 means no flush
  task automatic run_op(input logic [31:0] op, input int flush_cyc);
    step();
    exe_valid = 1'b1; exp_en = 1'b1; flush = 1'b0; operand_in = op;
    #1;
    chk1("c0_freeze", freeze, 1'b1);
    chk1("c0_busy", busy, 1'b0);
    chk("c0_data", exp_data, op);
    if (flush_cyc < 0) sb.push_back(f(op));
    for (int c = 1; c <= LAT; c++) begin
      step();
      operand_in = 32'hFFFF_FFFF;
      flush = (c == flush_cyc);
      #1;
      if (c == flush_cyc) begin
        chk1("flush_freeze", freeze, 1'b0);
        chk1("flush_done", exp_done, 1'b0);
        chk("flush_result", exp_result, last_res);
        step();
        flush = 1'b0; exe_valid = 1'b0; exp_en = 1'b0;
        #1;
        chk1("post_flush_busy", busy, 1'b0);
        chk1("post_flush_freeze", freeze, 1'b0);
        chk("post_flush_result", exp_result, last_res);
        return;
      end
      chk1("run_freeze", freeze, 1'b1);
      chk1("run_busy", busy, 1'b1);
      chk1("run_done", exp_done, 1'b0);
      chk("run_data", exp_data, op);
    end
    step();
    #1;
    chk1("done_pulse", exp_done, 1'b1);
    chk1("done_freeze", freeze, 1'b0);
    chk1("done_busy", busy, 1'b1);
    chk("done_data", exp_data, op);
    chk("done_result", exp_result, f(op));
    last_res = f(op);
  endtask

  initial begin
    // Reset state, sampled while reset is still asserted
    #3;
    chk1("rst_freeze", freeze, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", exp_done, 1'b0);
    chk("rst_result", exp_result, 32'h0);
    operand_in = 32'h1357_9BDF;
    #1;
    chk("rst_data_pass", exp_data, 32'h1357_9BDF);
    #8 rst = 1'b0;

    // Bubbles and non-exponent instructions have no effect
    for (int i = 0; i < 20; i++) begin
      step();
      exe_valid = (i >= 10);
      exp_en = 1'b0;
      operand_in = $urandom;
      #1;
      chk1("idle_freeze", freeze, 1'b0);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_done", exp_done, 1'b0);
      chk("idle_result", exp_result, 32'h0);
      chk("idle_data_pass", exp_data, operand_in);
    end
`ifdef EXP_STALL_CNT_EN
    chk("stall_idle", stall_cycles, 32'd0);
`endif

    // Single op, then back-to-back op starting at cycle 10
    run_op(32'h0000_0003, -1);
    run_op(32'h8000_0011, -1);
    idle_cycle();
    chk1("after_b2b_freeze", freeze, 1'b0);
`ifdef EXP_STALL_CNT_EN
    chk("stall_two_ops", stall_cycles, 32'd18);
`endif

    // Flush in RUN cycle 4
    run_op(32'h0000_0042, 4);
`ifdef EXP_STALL_CNT_EN
    chk("stall_flushed", stall_cycles, 32'd22);
`endif

    // Flush during the start cycle suppresses the start
    step();
    exe_valid = 1'b1; exp_en = 1'b1; flush = 1'b1; operand_in = 32'h55;
    #1;
    chk1("flush_start_freeze", freeze, 1'b0);
    idle_cycle();
    chk1("flush_start_busy", busy, 1'b0);

    // Another op, then flush during DONE kills the pulse
    run_op(32'h0000_0007, -1);
    idle_cycle();
    step();
    exe_valid = 1'b1; exp_en = 1'b1; flush = 1'b0; operand_in = 32'h0000_0009;
    for (int c = 1; c <= LAT; c++) step();
    step();
    flush = 1'b1;
    #1;
    chk1("done_flush_done", exp_done, 1'b0);
    chk("done_flush_result", exp_result, f(32'h9));
    last_res = f(32'h9);
    idle_cycle();
    chk1("done_flush_busy", busy, 1'b0);

    // Async reset in the middle of RUN
    sb.push_back(f(32'hABCD));
    step();
    exe_valid = 1'b1; exp_en = 1'b1; operand_in = 32'hABCD;
    step(); step(); step();
    operand_in = 32'hFFFF_FFFF;
    #2 rst = 1'b1;
    #1;
    chk1("arst_freeze", freeze, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk("arst_result", exp_result, 32'h0);
    chk("arst_data", exp_data, 32'hFFFF_FFFF);
`ifdef EXP_STALL_CNT_EN
    chk("arst_stall", stall_cycles, 32'd0);
`endif
    sb.delete();
    exe_valid = 1'b0; exp_en = 1'b0;
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      chk1("post_arst_busy", busy, 1'b0);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exp_seq_ctrl.md
# exp_seq_ctrl

Sequencing controller for the multi-cycle exponent unit in the execute stage. When a valid exponent instruction reaches EXE, the block holds the forwarded Rn operand stable at the unit's input and freezes the upstream pipeline until the result is ready. It latches the result and releases the pipeline with a one-cycle completion pulse. It sits beside the EXE datapath, between the Rn forwarding mux and the ALU/exponent result mux, and drives the hazard/freeze network.

## Interface
Parameters:
- LATENCY, 8: exponent unit latency in cycles, counted from the first cycle the operand is presented; legal range ≥1.
- CNT_W, 4: countdown width; must satisfy 2^CNT_W > LATENCY-1.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- exe_valid  in  1  EXE stage holds a real instruction, not a bubble.
- exp_en  in  1  decoded: the EXE instruction is an exponent op.
- flush  in  1  pipeline flush (taken branch); kills the EXE instruction.
- operand_in  in  32  forwarded Rn value (Rn forwarding mux output).
- exp_res  in  32  raw exponent unit output.
- exp_data  out  32  operand driven to the exponent unit.
- exp_result  out  32  latched exponent result, fed to the ALU/exponent mux.
- freeze  out  1  stall IF/ID and ID/EXE registers and the PC.
- exp_done  out  1  single-cycle pulse; exp_result is valid and EXE/MEM may capture.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- start = exe_valid & exp_en & ~flush & (state==IDLE).
- IDLE:
  - exp_data = operand_in (pass-through).
  - On start: latch operand_in into the hold register, load cnt = LATENCY-1, go to RUN.
- RUN:
  - exp_data = hold register.
  - While cnt≠0, decrement cnt.
  - When cnt==0, capture exp_res into exp_result and go to DONE.
- DONE:
  - exp_data = hold register.
  - Return to IDLE unconditionally.
  - Inputs are ignored in DONE. The same instruction is still in EXE with exp_en high, and it must not retrigger.
- freeze = ~rst & (start | state==RUN). Freeze is low in DONE, so the pipeline advances at the end of DONE.
- exp_done = (state==DONE) & ~flush.
- busy = (state==RUN) | (state==DONE).
- Flush handling:
  - flush in RUN: abort to IDLE next edge; exp_result unchanged; no exp_done; freeze drops the same cycle (combinational).
  - flush in the start cycle: no start.
  - flush in DONE: exp_done suppressed; state still goes to IDLE.
- exp_result holds its value until the next capture; it is never cleared except by reset.
- Reset values:
  - state IDLE, cnt 0, hold register 0, exp_result 0.
  - freeze 0, exp_done 0, busy 0.
  - exp_data equals operand_in after reset, because the block is in IDLE.
- Reset asserted mid-RUN: immediate return to IDLE; freeze drops asynchronously.

## Timing
- Cycle 0 (start cycle): freeze=1; operand on exp_data.
- Cycles 1..LATENCY: RUN; freeze=1.
  - Capture happens at the end of cycle LATENCY.
  - The operand has been stable for LATENCY+1 cycles at that point.
- Cycle LATENCY+1: DONE; exp_done=1; freeze=0.
- The earliest next start is cycle LATENCY+2, i.e. back-to-back exponent ops are separated by one IDLE cycle.
- Total freeze length per op: LATENCY+1 cycles.
- LATENCY=1: cnt loads 0; a single RUN cycle; DONE at cycle 2.
- Non-exponent instructions and bubbles (exe_valid=0): no effect; freeze stays 0.

## Configuration
- Macro EXP_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles (out, 32).
  - Increments on every cycle with freeze=1, including the start cycle.
  - Saturates at 0xFFFFFFFF; resets to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

## Test plan
All scenarios use LATENCY=8.
- Reset then idle, exe_valid=0 for 20 cycles -> freeze=0, busy=0, exp_done never pulses, exp_result=0.
- Start with operand_in=0x00000003, exp_res model = f(operand) after 8 cycles:
  - freeze=1 for exactly 9 cycles.
  - exp_done pulses in cycle 9.
  - exp_result=f(3).
  - exp_data=3 throughout, even when operand_in changes to 0xFFFFFFFF after cycle 0.
- Two exponent ops back-to-back: second start occurs at cycle 10, not 9; each gets its own done pulse and result.
- flush asserted in cycle 4 of RUN:
  - freeze drops in cycle 4; state IDLE at cycle 5.
  - No exp_done; exp_result keeps its previous value.
- rst pulsed asynchronously mid-RUN (between edges) -> freeze and busy drop immediately; all registers return to reset values.
- With EXP_STALL_CNT_EN defined, two completed ops -> stall_cycles=18; with one op flushed at cycle 4 -> that op adds 4.
